// File: rtl/fifo_reader_pkg.sv
// Width helpers shared by the fifo_reader top and its output buffer.
package fifo_reader_pkg;

  localparam int MAX_BUF_DEPTH = 8;

  // Pointer width; a single-entry buffer still gets one pointer bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Circular register buffer: writes land at wr_ptr, the head entry sits at rd_ptr,
// both pointers wrap explicitly at DEPTH so non-power-of-2 depths work.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    head_valid,
  output logic [WIDTH-1:0]        head_data
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (rd_en) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // The reserve rule upstream must keep writes away from a full buffer.
  always @(posedge clk) begin
    if (!rst) assert (!(wr_en && (count_q == CW'(DEPTH))));
  end

  assign count      = count_q;
  assign head_valid = valid_q;
  assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_reader.sv
// Drains a synchronous fifo read port (FWFT or one-cycle latency) into a
// valid/ready stream, reserving buffer space for every read before issuing it.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FWFT      = 1,
  parameter int BUF_DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  output logic                        fifo_rd,
  input  logic [WIDTH-1:0]            fifo_dout,
  input  logic                        fifo_dvld,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_data,
  output logic [cnt_w(BUF_DEPTH)-1:0] buf_count,
  output logic                        err_dvld
);

  localparam int            CW        = cnt_w(BUF_DEPTH);
  localparam bit            IS_FWFT   = (FWFT != 0);
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(BUF_DEPTH);

  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;
  logic [CW:0]   reserve;
  logic          dvld_hit, dvld_stray;
  logic          wr_en, pop;

  // fifo_rd depends only on registered occupancy, never on m_ready.
  always_comb begin
    reserve    = {1'b0, buf_count} + {1'b0, inflight_q};
    fifo_rd    = !rst && !fifo_empty && (reserve < DEPTH_LIM);
    pop        = m_valid && m_ready;
    dvld_hit   = !IS_FWFT && fifo_dvld && (inflight_q != '0);
    dvld_stray = !IS_FWFT && fifo_dvld && (inflight_q == '0);
    wr_en      = IS_FWFT ? fifo_rd : dvld_hit;
    inflight_d = inflight_q;
    if (!IS_FWFT) begin
      case ({fifo_rd, dvld_hit})
        2'b10:   inflight_d = inflight_q + CW'(1);
        2'b01:   inflight_d = inflight_q - CW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
    err_d = err_q || dvld_stray;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  fifo_reader_buf #(
    .WIDTH(WIDTH),
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (fifo_dout),
    .rd_en     (pop),
    .count     (buf_count),
    .head_valid(m_valid),
    .head_data (m_data)
  );

  assign err_dvld = err_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a standard-latency instance (k=0) and an FWFT
// instance (k=1), each fed by a behavioural fifo model, outputs logged at negedge.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rdy;
  logic        spur;
  logic [31:0] spur_data;
  logic [1:0]  empty;
  logic        dvld_s;
  logic [31:0] dout_s;
  wire  [31:0] dout_f;
  wire  [1:0]  rd, mv, err;
  wire  [31:0] md [2];
  wire  [1:0]  bc [2];

  logic [31:0] mem [2][4096];
  int          head [2];
  int          tail [2];

  int          cyc;
  int          n_out [2];
  int          n_rd [2];
  logic [31:0] out_d [2][4096];
  int          out_c [2][4096];
  int          rd_c [2][4096];
  int          inf_rd, inf_dv, inf_now, max_inf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_reader #(.WIDTH(32), .FWFT(0), .BUF_DEPTH(3)) dut0 (
    .clk(clk), .rst(rst), .fifo_empty(empty[0]), .fifo_rd(rd[0]),
    .fifo_dout(dout_s), .fifo_dvld(dvld_s), .m_valid(mv[0]), .m_ready(rdy[0]),
    .m_data(md[0]), .buf_count(bc[0]), .err_dvld(err[0]));

  fifo_reader #(.WIDTH(32), .FWFT(1), .BUF_DEPTH(3)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(empty[1]), .fifo_rd(rd[1]),
    .fifo_dout(dout_f), .fifo_dvld(1'b0), .m_valid(mv[1]), .m_ready(rdy[1]),
    .m_data(md[1]), .buf_count(bc[1]), .err_dvld(err[1]));

  // Fifo models: tb owns tail (push), the model owns head (pop on rd).
  assign empty  = {head[1] == tail[1], head[0] == tail[0]};
  assign dout_f = mem[1][head[1][11:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd[0]) head[0] <= head[0] + 1;
    if (rd[1]) head[1] <= head[1] + 1;
    dvld_s <= rd[0] | spur;
    dout_s <= rd[0] ? mem[0][head[0][11:0]] : spur_data;
  end

  always @(negedge clk) begin
    if (rst) begin
      inf_dv <= inf_rd;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mv[k] && rdy[k]) begin
          out_d[k][n_out[k]] <= md[k];
          out_c[k][n_out[k]] <= cyc;
          n_out[k]           <= n_out[k] + 1;
        end
        if (rd[k]) begin
          rd_c[k][n_rd[k]] <= cyc;
          n_rd[k]          <= n_rd[k] + 1;
        end
      end
      inf_now = inf_rd - inf_dv;
      if (inf_now > max_inf) max_inf <= inf_now;
      if (rd[0]) inf_rd <= inf_rd + 1;
      if (dvld_s && inf_now > 0) inf_dv <= inf_dv + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int k, input logic [31:0] v);
    mem[k][tail[k][11:0]] = v;
    tail[k]++;
  endtask

  task automatic test_reset();
    push(0, 32'hAAAA_0000);
    push(1, 32'hAAAA_0001);
    #12;
    for (int k = 0; k < 2; k++) begin
      checks++; if (rd[k] !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd[%0d]: got %b want 0", k, rd[k]); end
      checks++; if (mv[k] !== 1'b0) begin errors++; $display("FAIL reset_m_valid[%0d]: got %b want 0", k, mv[k]); end
      checks++; if (md[k] !== 32'h0) begin errors++; $display("FAIL reset_m_data[%0d]: got %h want 0", k, md[k]); end
      checks++; if (bc[k] !== 2'd0) begin errors++; $display("FAIL reset_buf_count[%0d]: got %0d want 0", k, bc[k]); end
      checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL reset_err_dvld[%0d]: got %b want 0", k, err[k]); end
      tail[k] = head[k];
    end
    step(1);
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_stream();
    int bo [2];
    int br [2];
    int lat;
    for (int k = 0; k < 2; k++) begin bo[k] = n_out[k]; br[k] = n_rd[k]; end
    rdy = 2'b11;
    for (int i = 0; i < 10; i++) begin push(0, 32'(i)); push(1, 32'(i)); end
    step(25);
    for (int k = 0; k < 2; k++) begin
      lat = (k == 1) ? 1 : 2;
      checks++; if (n_rd[k] - br[k] !== 10) begin errors++; $display("FAIL stream_rd_count[%0d]: got %0d want 10", k, n_rd[k] - br[k]); end
      for (int i = 1; i < 10; i++) begin
        checks++; if (rd_c[k][br[k]+i] !== rd_c[k][br[k]] + i) begin errors++; $display("FAIL stream_rd_consec[%0d] i=%0d: got cyc %0d want %0d", k, i, rd_c[k][br[k]+i], rd_c[k][br[k]] + i); end
      end
      checks++; if (n_out[k] - bo[k] !== 10) begin errors++; $display("FAIL stream_out_count[%0d]: got %0d want 10", k, n_out[k] - bo[k]); end
      for (int i = 0; i < 10; i++) begin
        checks++; if (out_d[k][bo[k]+i] !== 32'(i)) begin errors++; $display("FAIL stream_data[%0d] i=%0d: got %h want %h", k, i, out_d[k][bo[k]+i], i); end
        checks++; if (out_c[k][bo[k]+i] !== rd_c[k][br[k]] + lat + i) begin errors++; $display("FAIL stream_latency[%0d] i=%0d: got cyc %0d want %0d", k, i, out_c[k][bo[k]+i], rd_c[k][br[k]] + lat + i); end
      end
    end
    checks++; if (max_inf > 2) begin errors++; $display("FAIL stream_max_inflight: got %0d want <=2", max_inf); end
  endtask

  task automatic test_backpressure();
    int bo [2];
    int br [2];
    for (int k = 0; k < 2; k++) begin bo[k] = n_out[k]; br[k] = n_rd[k]; end
    rdy = 2'b00;
    for (int i = 0; i < 10; i++) begin push(0, 32'(100 + i)); push(1, 32'(100 + i)); end
    step(20);
    for (int k = 0; k < 2; k++) begin
      checks++; if (n_rd[k] - br[k] !== 3) begin errors++; $display("FAIL bp_rd_count[%0d]: got %0d want 3", k, n_rd[k] - br[k]); end
      checks++; if (bc[k] !== 2'd3) begin errors++; $display("FAIL bp_buf_count[%0d]: got %0d want 3", k, bc[k]); end
      checks++; if (n_out[k] - bo[k] !== 0) begin errors++; $display("FAIL bp_no_output[%0d]: got %0d want 0", k, n_out[k] - bo[k]); end
    end
    checks++; if (inf_rd - inf_dv !== 0) begin errors++; $display("FAIL bp_inflight: got %0d want 0", inf_rd - inf_dv); end
    rdy = 2'b11;
    step(25);
    for (int k = 0; k < 2; k++) begin
      checks++; if (n_out[k] - bo[k] !== 10) begin errors++; $display("FAIL bp_out_count[%0d]: got %0d want 10", k, n_out[k] - bo[k]); end
      for (int i = 0; i < 10; i++) begin
        checks++; if (out_d[k][bo[k]+i] !== 32'(100 + i)) begin errors++; $display("FAIL bp_data[%0d] i=%0d: got %h want %h", k, i, out_d[k][bo[k]+i], 100 + i); end
      end
    end
  endtask

  task automatic test_random();
    int bo [2];
    int sent = 0;
    int guard = 0;
    for (int k = 0; k < 2; k++) bo[k] = n_out[k];
    while ((n_out[0] - bo[0] < 1000 || n_out[1] - bo[1] < 1000) && guard < 8000) begin
      rdy[0] = 1'($urandom_range(0, 1));
      rdy[1] = 1'($urandom_range(0, 1));
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        push(0, 32'hC000_0000 + 32'(sent));
        push(1, 32'hC000_0000 + 32'(sent));
        sent++;
      end
      step(1);
      guard++;
    end
    rdy = 2'b11;
    step(5);
    for (int k = 0; k < 2; k++) begin
      checks++; if (n_out[k] - bo[k] !== 1000) begin errors++; $display("FAIL rand_out_count[%0d]: got %0d want 1000", k, n_out[k] - bo[k]); end
      for (int i = 0; i < 1000; i++) begin
        checks++;
        if (out_d[k][bo[k]+i] !== 32'hC000_0000 + 32'(i)) begin
          errors++;
          $display("FAIL rand_order[%0d] i=%0d: got %h want %h", k, i, out_d[k][bo[k]+i], 32'hC000_0000 + 32'(i));
          break;
        end
      end
      checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL rand_err_dvld[%0d]: got %b want 0", k, err[k]); end
    end
  endtask

  task automatic test_spurious();
    int bo;
    bo = n_out[0];
    rdy[0] = 1'b0;
    push(0, 32'h0000_0077);
    step(6);
    checks++; if (bc[0] !== 2'd1) begin errors++; $display("FAIL spur_pre_count: got %0d want 1", bc[0]); end
    spur = 1'b1;
    spur_data = 32'hDEAD_BEEF;
    step(1);
    spur = 1'b0;
    step(4);
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b want 1", err[0]); end
    checks++; if (bc[0] !== 2'd1) begin errors++; $display("FAIL spur_count_unchanged: got %0d want 1", bc[0]); end
    step(10);
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b want 1", err[0]); end
    checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL spur_err_fwft: got %b want 0", err[1]); end
    rdy[0] = 1'b1;
    step(6);
    checks++; if (n_out[0] - bo !== 1) begin errors++; $display("FAIL spur_out_count: got %0d want 1", n_out[0] - bo); end
    checks++; if (out_d[0][bo] !== 32'h0000_0077) begin errors++; $display("FAIL spur_out_data: got %h want 00000077", out_d[0][bo]); end
  endtask

  task automatic test_reset_mid();
    int bo [2];
    int guard = 0;
    rdy = 2'b00;
    for (int i = 0; i < 5; i++) begin push(0, 32'(200 + i)); push(1, 32'(200 + i)); end
    step(1);
    while (bc[0] !== 2'd2 && guard < 20) begin step(1); guard++; end
    checks++; if (bc[0] !== 2'd2) begin errors++; $display("FAIL mid_pre_count: got %0d want 2", bc[0]); end
    checks++; if (inf_rd - inf_dv !== 1) begin errors++; $display("FAIL mid_pre_inflight: got %0d want 1", inf_rd - inf_dv); end
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (rd[k] !== 1'b0) begin errors++; $display("FAIL mid_fifo_rd[%0d]: got %b want 0", k, rd[k]); end
      checks++; if (mv[k] !== 1'b0) begin errors++; $display("FAIL mid_m_valid[%0d]: got %b want 0", k, mv[k]); end
      checks++; if (md[k] !== 32'h0) begin errors++; $display("FAIL mid_m_data[%0d]: got %h want 0", k, md[k]); end
      checks++; if (bc[k] !== 2'd0) begin errors++; $display("FAIL mid_buf_count[%0d]: got %0d want 0", k, bc[k]); end
      checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL mid_err_dvld[%0d]: got %b want 0", k, err[k]); end
    end
    step(2);
    for (int k = 0; k < 2; k++) begin tail[k] = head[k]; bo[k] = n_out[k]; end
    rst = 1'b0;
    step(1);
    push(0, 32'h5A5A_0001);
    push(1, 32'h5A5A_0001);
    rdy = 2'b11;
    step(8);
    for (int k = 0; k < 2; k++) begin
      checks++; if (n_out[k] - bo[k] !== 1) begin errors++; $display("FAIL post_out_count[%0d]: got %0d want 1", k, n_out[k] - bo[k]); end
      checks++; if (out_d[k][bo[k]] !== 32'h5A5A_0001) begin errors++; $display("FAIL post_out_data[%0d]: got %h want 5a5a0001", k, out_d[k][bo[k]]); end
      checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL post_err_dvld[%0d]: got %b want 0", k, err[k]); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    rdy       = 2'b00;
    spur      = 1'b0;
    spur_data = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
